// File: rtl/ws2812_serial_tx.sv
// ws2812_serial_tx: serialises a packed GRB frame onto a WS2812B data line.
// The frame is snapshotted on start, sent MSB-first as cycle-counted high/low
// pulses, and closed with a latch low period followed by a one-cycle done.
// Optional build macro WS2812_AUTO_REFRESH_EN: ignore start and resend
// frameIn continuously, reloading it at every frame boundary.
module ws2812_serial_tx #(
  parameter int NUM_LEDS = 4,
  parameter int T0H      = 40,
  parameter int T0L      = 85,
  parameter int T1H      = 80,
  parameter int T1L      = 45,
  parameter int TLATCH   = 6000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [24*NUM_LEDS-1:0]  frameIn,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    dout
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int FW   = 24 * NUM_LEDS;
  localparam int TMAX = max2(max2(max2(T0H, T0L), max2(T1H, T1L)), TLATCH);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = $clog2(FW);

  // Terminal timer values: a phase of N cycles ends when the timer reads N-1.
  localparam logic [TW-1:0] T0H_END   = TW'(T0H - 1);
  localparam logic [TW-1:0] T0L_END   = TW'(T0L - 1);
  localparam logic [TW-1:0] T1H_END   = TW'(T1H - 1);
  localparam logic [TW-1:0] T1L_END   = TW'(T1L - 1);
  localparam logic [TW-1:0] LATCH_END = TW'(TLATCH - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FW - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t          state;
  logic [FW-1:0]   shift_reg;
  logic [BW-1:0]   bit_cnt;
  logic [TW-1:0]   timer;
  logic            cur_bit;
  logic [TW-1:0]   high_end;
  logic [TW-1:0]   low_end;
  logic            go;

  // The bit on the wire is always the shift register MSB; it picks both phases.
  assign cur_bit  = shift_reg[FW-1];
  assign high_end = cur_bit ? T1H_END : T0H_END;
  assign low_end  = cur_bit ? T1L_END : T0L_END;

`ifdef WS2812_AUTO_REFRESH_EN
  // Self-starting: the strip is refreshed without any request.
  logic unused_start;
  assign unused_start = start;
  assign go = 1'b1;
`else
  assign go = start;
`endif

  // Frame sequencer: IDLE -> (HIGH -> LOW) per bit -> LATCH -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      timer     <= '0;
      dout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dout <= 1'b0;
          busy <= 1'b0;
          if (go) begin
            shift_reg <= frameIn;
            bit_cnt   <= BIT_LAST;
            timer     <= '0;
            state     <= HIGH;
            dout      <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HIGH: begin
          if (timer == high_end) begin
            timer <= '0;
            state <= LOW;
            dout  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LOW: begin
          if (timer == low_end) begin
            timer <= '0;
            if (bit_cnt == '0) begin
              state <= LATCH;
            end else begin
              shift_reg <= {shift_reg[FW-2:0], 1'b0};
              bit_cnt   <= bit_cnt - 1'b1;
              state     <= HIGH;
              dout      <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LATCH: begin
          if (timer == LATCH_END) begin
            timer <= '0;
            done  <= 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
            // Next frame starts immediately; busy never drops.
            shift_reg <= frameIn;
            bit_cnt   <= BIT_LAST;
            state     <= HIGH;
            dout      <= 1'b1;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          dout  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_serial_tx.sv
// tb_ws2812_serial_tx: scoreboard bench for ws2812_serial_tx.
// A small-timing instance is driven with random frames; accepted frames are
// queued with their accept edge, and a monitor rebuilds the expected waveform
// from the bit-period rules and compares it cycle by cycle. A second instance
// with default timing sends one all-zero frame and has its pulse widths measured.
module tb_ws2812_serial_tx;

  localparam int A0H = 2, A0L = 3, A1H = 4, A1L = 1, ALAT = 5;

  logic        clk = 1'b0;
  logic        reset, start, busy, done, dout;
  logic [23:0] frame_in;
  logic        reset2, start2, busy2, done2, dout2;
  logic [95:0] frame2;

  always #5 clk = ~clk;

  ws2812_serial_tx #(.NUM_LEDS(1), .T0H(A0H), .T0L(A0L), .T1H(A1H), .T1L(A1L), .TLATCH(ALAT)) dut (
    .clk(clk), .reset(reset), .frameIn(frame_in), .start(start),
    .busy(busy), .done(done), .dout(dout));

  ws2812_serial_tx dut_dflt (
    .clk(clk), .reset(reset2), .frameIn(frame2), .start(start2),
    .busy(busy2), .done(done2), .dout(dout2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [23:0] frame;
    int          edge_no;
  } item_t;

  item_t sb_q[$];
  int    next_free;

  function automatic int bit_period(input logic b);
    return b ? (A1H + A1L) : (A0H + A0L);
  endfunction

  function automatic int frame_len(input logic [23:0] f);
    int n = ALAT;
    for (int i = 0; i < 24; i++) n += bit_period(f[i]);
    return n;
  endfunction

  // ---------------- monitor ----------------
  bit    exp_wave[$];
  bit    in_frame = 0;
  bit    expect_done = 0;
  int    pos = 0;
  int    wave_err = 0;
  int    stray = 0;
  int    last_done_cyc = -1000;
  item_t cur;
  int    mh, ml;

  always @(negedge clk) begin
    if (!reset) begin
      in_frame    = 0;
      expect_done = 0;
      if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) stray++;
    end else if (expect_done) begin
      expect_done = 0;
      if (done === 1'b1) last_done_cyc = cyc;
      check("done_pulse", int'(done), 1);
      check("done_cycle_busy", int'(busy), 0);
      check("done_cycle_dout", int'(dout), 0);
    end else begin
      if (!in_frame && dout === 1'b1) begin
        if (sb_q.size() == 0) begin
          stray++;
        end else begin
          cur = sb_q.pop_front();
          check("first_high_latency", cyc, cur.edge_no);
          exp_wave.delete();
          for (int i = 23; i >= 0; i--) begin
            mh = cur.frame[i] ? A1H : A0H;
            ml = cur.frame[i] ? A1L : A0L;
            repeat (mh) exp_wave.push_back(1'b1);
            repeat (ml) exp_wave.push_back(1'b0);
          end
          repeat (ALAT) exp_wave.push_back(1'b0);
          pos      = 0;
          wave_err = 0;
          in_frame = 1;
        end
      end
      if (in_frame) begin
        if (dout !== exp_wave[pos] || busy !== 1'b1 || done !== 1'b0) wave_err++;
        pos++;
        if (pos == exp_wave.size()) begin
          in_frame    = 0;
          expect_done = 1;
          check("frame_wave_errors", wave_err, 0);
        end
      end else if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        stray++;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; start/frame_in are sampled on the coming edge cyc+1.
  task automatic drive(input logic s, input logic [23:0] f);
    item_t it;
    start    = s;
    frame_in = f;
    if (s && (cyc + 1) >= next_free) begin
      it.frame   = f;
      it.edge_no = cyc + 1;
      sb_q.push_back(it);
      next_free = cyc + 1 + frame_len(f) + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    while (cyc + 1 < next_free) drive(1'b0, 24'($urandom));
    repeat (2) drive(1'b0, 24'($urandom));
  endtask

  bit dflt_flag = 0;

  initial begin
    logic [23:0] f;
    int e, off;
    reset = 1'b0; start = 1'b0; frame_in = '0; next_free = 0;
    // Reset held with start asserted and frame toggling.
    for (int k = 0; k < 4; k++) begin
      start = 1'b1; frame_in = 24'($urandom);
      @(posedge clk); #1;
      check("reset_dout", int'(dout), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
    end
    reset = 1'b1; start = 1'b0;
    repeat (3) drive(1'b0, 24'($urandom));
    check("idle_busy", int'(busy), 0);
    check("idle_dout", int'(dout), 0);

    // Directed single frame.
    e = cyc + 1;
    drive(1'b1, 24'h800001);
    wait_idle();
    check("done_offset", last_done_cyc - e + 1, 1 + (A1H + A1L) + 22 * (A0H + A0L) + (A1H + A1L) + ALAT);

    // Random frames with an ignored mid-frame start carrying a different frame.
    for (int r = 0; r < 4; r++) begin
      f = 24'($urandom);
      drive(1'b1, f);
      repeat ($urandom_range(5, 100)) drive(1'b0, 24'($urandom));
      drive(1'b1, ~f);
      wait_idle();
    end

    // Start held high: back-to-back frames, each snapshotting frame_in at its accept edge.
    repeat (400) drive(1'b1, 24'($urandom));
    wait_idle();

    // Reset during the 10th bit's high phase.
    f = 24'($urandom);
    e = cyc + 1;
    drive(1'b1, f);
    off = 0;
    for (int i = 23; i >= 15; i--) off += bit_period(f[i]);
    while (cyc < e + off) drive(1'b0, 24'($urandom));
    #2;
    check("pre_reset_dout", int'(dout), 1);
    reset = 1'b0;
    #1;
    check("async_reset_dout", int'(dout), 0);
    check("async_reset_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    next_free = 0;
    repeat (5) drive(1'b0, 24'($urandom));

    // A fresh frame after the abandoned one.
    drive(1'b1, 24'($urandom));
    wait_idle();

    for (int k = 0; k < 2000 && (sb_q.size() != 0 || in_frame || expect_done); k++)
      drive(1'b0, 24'($urandom));
    check("scoreboard_drained", int'(sb_q.size() != 0 || in_frame || expect_done), 0);
    check("stray_events", stray, 0);

    for (int k = 0; k < 30000 && !dflt_flag; k++) @(posedge clk);
    check("dflt_finished", int'(dflt_flag), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Default-timing instance: one all-zero 4-LED frame.
  initial begin
    int hi, lo, bad_hi, bad_lo, e2;
    bad_hi = 0; bad_lo = 0; lo = 0;
    reset2 = 1'b0; start2 = 1'b0; frame2 = '0;
    repeat (2) @(posedge clk);
    #1 reset2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b1; e2 = cyc + 1;
    @(posedge clk); #1;
    start2 = 1'b0; frame2 = {3{$urandom}};
    @(negedge clk);
    check("dflt_latency", cyc, e2);
    check("dflt_first_dout", int'(dout2), 1);
    for (int b = 0; b < 96; b++) begin
      hi = 0;
      while (dout2 === 1'b1 && hi < 200) begin hi++; @(negedge clk); end
      if (hi != 40) bad_hi++;
      lo = 0;
      while (dout2 === 1'b0 && done2 !== 1'b1 && lo < 7000) begin lo++; @(negedge clk); end
      if (b < 95 && lo != 85) bad_lo++;
    end
    check("dflt_high_widths", bad_hi, 0);
    check("dflt_low_widths", bad_lo, 0);
    check("dflt_tail_low", lo, 85 + 6000);
    check("dflt_done", int'(done2), 1);
    check("dflt_done_busy", int'(busy2), 0);
    dflt_flag = 1;
  end

endmodule
